// File: rtl/gpo_event_scheduler.sv
// gpo_event_scheduler
// Timestamped event FIFO feeding a GPO core. Events are written with a 64-bit
// due time and a 128-bit payload. While RUNNING, a free-running time counter
// advances once per cycle. The head event is issued when its time has arrived,
// the core is idle and no clear is in progress. The issue strobe and payload
// appear one cycle after the issuing edge.
// Events are issued strictly in write order. A head that is not yet due
// blocks every entry behind it.
module gpo_event_scheduler #(
  parameter int DEPTH          = 16,
  parameter int CHANNEL_LENGTH = 12
) (
  input  logic                   CLK100MHZ,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   clear,
  input  logic                   wr_en,
  input  logic [63:0]            wr_time,
  input  logic [127:0]           wr_data,
  input  logic                   busy,
  output logic                   counter_matched,
  output logic [127:0]           gpo_data,
  output logic [63:0]            time_now,
  output logic                   running,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   fifo_full,
  output logic                   fifo_empty,
  output logic                   overflow_err,
  output logic                   late_err
);

  localparam int TIME_W = 64;
  localparam int DATA_W = 128;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = PTR_W + 1;

  localparam logic [0:0] ST_STOPPED = 1'b0;
  localparam logic [0:0] ST_RUNNING = 1'b1;

  // Reject unsupported FIFO geometries at elaboration time.
  if (DEPTH < 4 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0 || CHANNEL_LENGTH < 1) begin : g_bad_params
    $error("gpo_event_scheduler: DEPTH must be a power of 2 in 4..256");
  end

  logic              rst_meta_p0;
  logic              rst_sync_p1;
  logic              rst_n_int;

  logic [0:0]        state;
  logic [PTR_W-1:0]  head_ptr;
  logic [PTR_W-1:0]  tail_ptr;
  logic [TIME_W-1:0] time_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [TIME_W-1:0] head_time;
  logic              head_due;
  logic              issue;
  logic              push;
  logic              drop;

  logic              vld_p1;
  logic [DATA_W-1:0] gpo_data_p1;

  // Reset synchroniser: asserts immediately, releases two clock edges later.
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      rst_meta_p0 <= 1'b0;
      rst_sync_p1 <= 1'b0;
    end else begin
      rst_meta_p0 <= 1'b1;
      rst_sync_p1 <= rst_meta_p0;
    end
  end

  assign rst_n_int = rst_sync_p1;

  // Status views of the FIFO level and the run state.
  assign fifo_full  = (fifo_level == LVL_W'(DEPTH));
  assign fifo_empty = (fifo_level == '0);
  assign running    = (state == ST_RUNNING);

  // The head is due once its time is at or before the counter (unsigned).
  // A full FIFO still accepts a write in the cycle its head is popped.
  assign head_time = time_mem[head_ptr];
  assign head_due  = (head_time <= time_now);
  assign issue     = running && !fifo_empty && head_due && !busy && !clear;
  assign push      = wr_en && !clear && (!fifo_full || issue);
  assign drop      = wr_en && !clear && fifo_full && !issue;

  // Run state: stop has priority over start. Clear leaves the state alone.
  always_ff @(posedge CLK100MHZ or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state <= ST_STOPPED;
    end else if (stop) begin
      state <= ST_STOPPED;
    end else if (start) begin
      state <= ST_RUNNING;
    end
  end

  // Time counter: advances while running and wraps silently.
  always_ff @(posedge CLK100MHZ or negedge rst_n_int) begin
    if (!rst_n_int) begin
      time_now <= '0;
    end else if (clear) begin
      time_now <= '0;
    end else if (running) begin
      time_now <= time_now + 64'd1;
    end
  end

  // Event storage. It is not reset; only the pointers and the level define
  // which entries are valid.
  always_ff @(posedge CLK100MHZ) begin
    if (push) begin
      time_mem[tail_ptr] <= wr_time;
      data_mem[tail_ptr] <= wr_data;
    end
  end

  // FIFO pointers and level. A push and a pop in the same cycle leave the level unchanged.
  always_ff @(posedge CLK100MHZ or negedge rst_n_int) begin
    if (!rst_n_int) begin
      head_ptr   <= '0;
      tail_ptr   <= '0;
      fifo_level <= '0;
    end else if (clear) begin
      head_ptr   <= '0;
      tail_ptr   <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        tail_ptr <= tail_ptr + PTR_W'(1);
      end
      if (issue) begin
        head_ptr <= head_ptr + PTR_W'(1);
      end
      case ({push, issue})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Sticky error flags. Overflow marks a dropped write. Late marks an event
  // issued after its own time had already passed.
  always_ff @(posedge CLK100MHZ or negedge rst_n_int) begin
    if (!rst_n_int) begin
      overflow_err <= 1'b0;
      late_err     <= 1'b0;
    end else if (clear) begin
      overflow_err <= 1'b0;
      late_err     <= 1'b0;
    end else begin
      if (drop) begin
        overflow_err <= 1'b1;
      end
      if (issue && (head_time < time_now)) begin
        late_err <= 1'b1;
      end
    end
  end

  // ---- issue stage -> output stage (p1) ----
  // The one-cycle strobe and its payload. The payload holds between issues.
  always_ff @(posedge CLK100MHZ or negedge rst_n_int) begin
    if (!rst_n_int) begin
      vld_p1      <= 1'b0;
      gpo_data_p1 <= '0;
    end else begin
      vld_p1 <= issue;
      if (issue) begin
        gpo_data_p1 <= data_mem[head_ptr];
      end
    end
  end

  assign counter_matched = vld_p1;
  assign gpo_data        = gpo_data_p1;

endmodule

// File: tb/tb_gpo_event_scheduler.sv
// Scoreboard bench for gpo_event_scheduler. The stimulus process writes
// events. For each event it pushes the expected (time_now, payload) pair seen
// with the strobe. A separate monitor pops and compares on every strobe.
module tb_gpo_event_scheduler;

  typedef struct packed {
    logic [63:0]  t;
    logic [127:0] d;
  } exp_t;

  logic         CLK100MHZ;
  logic         reset;
  logic         start;
  logic         stop;
  logic         clear;
  logic         wr_en;
  logic [63:0]  wr_time;
  logic [127:0] wr_data;
  logic         busy;
  logic         counter_matched;
  logic [127:0] gpo_data;
  logic [63:0]  time_now;
  logic         running;
  logic [4:0]   fifo_level;
  logic         fifo_full;
  logic         fifo_empty;
  logic         overflow_err;
  logic         late_err;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];

  localparam logic [127:0] DA = 128'h0000_0000_0000_00AA_1111_2222_3333_4444;
  localparam logic [127:0] DB = 128'h0000_0000_0000_00BB_5555_6666_7777_8888;
  localparam logic [127:0] DC = 128'h0000_0000_0000_00CC_9999_AAAA_BBBB_CCCC;
  localparam logic [127:0] DD = 128'h0000_0000_0000_00DD_0123_4567_89AB_CDEF;
  localparam logic [127:0] DE = 128'h0000_0000_0000_00EE_FEDC_BA98_7654_3210;
  localparam logic [127:0] DX = 128'h0000_0000_0000_0099_0000_0000_0000_0200;
  localparam logic [127:0] DG = 128'h0000_0000_0000_0077_0000_0000_0000_0003;

  gpo_event_scheduler #(.DEPTH(16), .CHANNEL_LENGTH(12)) dut (
    .CLK100MHZ       (CLK100MHZ),
    .reset           (reset),
    .start           (start),
    .stop            (stop),
    .clear           (clear),
    .wr_en           (wr_en),
    .wr_time         (wr_time),
    .wr_data         (wr_data),
    .busy            (busy),
    .counter_matched (counter_matched),
    .gpo_data        (gpo_data),
    .time_now        (time_now),
    .running         (running),
    .fifo_level      (fifo_level),
    .fifo_full       (fifo_full),
    .fifo_empty      (fifo_empty),
    .overflow_err    (overflow_err),
    .late_err        (late_err)
  );

  initial CLK100MHZ = 1'b0;
  always #5 CLK100MHZ = ~CLK100MHZ;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic expect_ev(input logic [63:0] t, input logic [127:0] d);
    exp_t e;
    e.t = t;
    e.d = d;
    sb_q.push_back(e);
  endtask

  task automatic write_ev(input logic [63:0] t, input logic [127:0] d);
    wr_en   = 1'b1;
    wr_time = t;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK100MHZ);
      if (counter_matched === 1'b1) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL strobe_unexpected actual time_now=%0d data=%0h required=no strobe",
                   time_now, gpo_data);
        end else begin
          e = sb_q.pop_front();
          if (time_now !== e.t || gpo_data !== e.d) begin
            failures++;
            $display("FAIL strobe actual time_now=%0d data=%0h required time_now=%0d data=%0h",
                     time_now, gpo_data, e.t, e.d);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation timeout");
  end

  initial begin : stimulus
    int guard;
    reset   = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    clear   = 1'b0;
    wr_en   = 1'b0;
    wr_time = '0;
    wr_data = '0;
    busy    = 1'b0;

    // Reset state
    #12;
    check("rst_running",  128'(running),         128'(0));
    check("rst_time",     128'(time_now),        128'(0));
    check("rst_level",    128'(fifo_level),      128'(0));
    check("rst_empty",    128'(fifo_empty),      128'(1));
    check("rst_full",     128'(fifo_full),       128'(0));
    check("rst_strobe",   128'(counter_matched), 128'(0));
    check("rst_gpo_data", gpo_data,              128'(0));
    check("rst_ovf",      128'(overflow_err),    128'(0));
    check("rst_late",     128'(late_err),        128'(0));
    tick();
    reset = 1'b1;
    repeat (3) tick();

    // Two events, both issued on time
    write_ev(64'd5, DA); expect_ev(64'd6, DA);
    write_ev(64'd7, DB); expect_ev(64'd8, DB);
    check("t1_level", 128'(fifo_level), 128'(2));
    pulse_start();
    check("t1_running", 128'(running), 128'(1));
    repeat (12) tick();
    check("t1_time",     128'(time_now),   128'(12));
    check("t1_late",     128'(late_err),   128'(0));
    check("t1_empty",    128'(fifo_empty), 128'(1));
    check("t1_hold",     gpo_data,         DB);
    check("t1_sb_drain", 128'(sb_q.size()), 128'(0));
    pulse_stop();
    check("t1_stop_time", 128'(time_now), 128'(13));
    repeat (3) tick();
    check("t1_time_hold", 128'(time_now), 128'(13));
    pulse_clear();
    check("t1_clear_time", 128'(time_now), 128'(0));

    // Due event held off by busy, issued late once busy falls
    busy = 1'b1;
    write_ev(64'd3, DC); expect_ev(64'd11, DC);
    pulse_start();
    guard = 0;
    while (time_now != 64'd10 && guard < 40) begin
      tick();
      guard++;
    end
    check("t2_reached_10", 128'(time_now), 128'(10));
    busy = 1'b0;
    repeat (3) tick();
    check("t2_late",     128'(late_err),   128'(1));
    check("t2_level",    128'(fifo_level), 128'(0));
    check("t2_sb_drain", 128'(sb_q.size()), 128'(0));
    pulse_stop();
    pulse_clear();
    check("t2_clear_late", 128'(late_err), 128'(0));

    // Fill, overflow, then write while full in the cycle a pop happens
    for (int i = 0; i < 16; i++) begin
      write_ev(64'(i), {64'hF111, 64'(i)});
      expect_ev(64'(i + 1), {64'hF111, 64'(i)});
    end
    check("t3_level_full", 128'(fifo_level), 128'(16));
    check("t3_full",       128'(fifo_full),  128'(1));
    write_ev(64'd0, 128'hDEAD_BEEF);
    check("t3_drop_level", 128'(fifo_level),   128'(16));
    check("t3_overflow",   128'(overflow_err), 128'(1));
    pulse_start();
    write_ev(64'd200, DX);
    check("t3_push_pop_level", 128'(fifo_level), 128'(16));
    repeat (20) tick();
    check("t3_level_rest", 128'(fifo_level), 128'(1));
    check("t3_late",       128'(late_err),   128'(0));
    check("t3_sb_drain",   128'(sb_q.size()), 128'(0));
    pulse_stop();
    pulse_clear();
    check("t3_clear_level", 128'(fifo_level),   128'(0));
    check("t3_clear_ovf",   128'(overflow_err), 128'(0));
    check("t3_clear_empty", 128'(fifo_empty),   128'(1));

    // A non-due head blocks a due entry behind it
    write_ev(64'd100, DD); expect_ev(64'd101, DD);
    write_ev(64'd2,   DE); expect_ev(64'd102, DE);
    pulse_start();
    repeat (110) tick();
    check("t4_late",     128'(late_err),   128'(1));
    check("t4_level",    128'(fifo_level), 128'(0));
    check("t4_hold",     gpo_data,         DE);
    check("t4_sb_drain", 128'(sb_q.size()), 128'(0));
    pulse_stop();
    pulse_clear();

    // Start and stop together, then clear while running
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("t5_both_running", 128'(running), 128'(0));
    repeat (3) tick();
    check("t5_both_time", 128'(time_now), 128'(0));
    pulse_start();
    repeat (5) tick();
    check("t5_run_time", 128'(time_now), 128'(5));
    for (int i = 0; i < 4; i++) begin
      write_ev(64'(1000 + i), {64'hC1EA, 64'(i)});
    end
    check("t5_level4", 128'(fifo_level), 128'(4));
    pulse_clear();
    check("t5_clr_level",   128'(fifo_level), 128'(0));
    check("t5_clr_time",    128'(time_now),   128'(0));
    check("t5_clr_running", 128'(running),    128'(1));
    check("t5_clr_empty",   128'(fifo_empty), 128'(1));
    tick();
    check("t5_time_after_clr", 128'(time_now), 128'(1));
    pulse_stop();
    pulse_clear();

    // Reset mid-run with pending events
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      write_ev(64'(5000 + i), {64'h5E5E, 64'(i)});
    end
    check("t6_level5", 128'(fifo_level), 128'(5));
    reset = 1'b0;
    #1;
    check("t6_rst_running", 128'(running),         128'(0));
    check("t6_rst_time",    128'(time_now),        128'(0));
    check("t6_rst_level",   128'(fifo_level),      128'(0));
    check("t6_rst_empty",   128'(fifo_empty),      128'(1));
    check("t6_rst_full",    128'(fifo_full),       128'(0));
    check("t6_rst_strobe",  128'(counter_matched), 128'(0));
    check("t6_rst_data",    gpo_data,              128'(0));
    check("t6_rst_ovf",     128'(overflow_err),    128'(0));
    check("t6_rst_late",    128'(late_err),        128'(0));
    repeat (2) tick();
    reset = 1'b1;
    repeat (6) tick();
    check("t6_rel_level",   128'(fifo_level), 128'(0));
    check("t6_rel_time",    128'(time_now),   128'(0));
    check("t6_rel_running", 128'(running),    128'(0));
    write_ev(64'd3, DG); expect_ev(64'd4, DG);
    pulse_start();
    repeat (10) tick();
    check("t6_new_data",  gpo_data,          DG);
    check("t6_new_late",  128'(late_err),    128'(0));
    check("t6_sb_drain",  128'(sb_q.size()), 128'(0));

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
